round_robin_lock_arbiter: RTL
=============================

# round_robin_lock_arbiter

- Shares one multi-cycle resource among four requesters.
- Arbitration is round-robin. The winner holds the resource until it signals `done` or until a hold limit expires.
- Requests are latched as pending, so one-cycle pulses are never lost.
- Sits in front of the shared datapath. It replaces single-cycle fixed-priority grant where transactions last more than one cycle.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles a grant may be held. Legal range 1..255.
- `clk`  input  1  rising-edge clock.
- `rstn`  input  1  asynchronous active-low reset.
- `req`  input  4  request per requester. Level or single-cycle pulse.
- `enable`  input  1  permits issuing new grants. Never pre-empts an active grant.
- `done`  input  1  current owner releases the resource. Ignored when no grant is active.
- `grant`  output  4  registered one-hot grant, or 0.
- `busy`  output  1  registered. Equals |grant.
- `timeout`  output  1  registered one-cycle pulse when a grant is force-released.

## Operation
- Pending register, per bit i:
  - pend[i] <= (pend[i] | req[i]) & ~issue[i].
  - issue is the one-hot grant being loaded this cycle.
  - A req asserted in the same cycle as its own issue is consumed by that issue and is not re-latched.
  - A req from the current owner during its hold re-latches and competes later.
- Candidates: cand = pend | req.
- Priority pointer `ptr` (2 bits):
  - Search order is ptr, ptr+1, ptr+2, ptr+3 mod 4.
  - After issuing to i, ptr <= (i+1) mod 4.
- State machine, states IDLE and HOLD:
  - IDLE: if enable and cand != 0, issue to the first candidate in pointer order; load grant; clear hold_cnt; go to HOLD. Otherwise grant stays 0.
  - HOLD, done=1: grant <= 0, go to IDLE, timeout stays 0.
  - HOLD, done=0 and hold_cnt == MAX_HOLD-1: grant <= 0, timeout <= 1 for one cycle, go to IDLE.
  - HOLD, otherwise: hold_cnt++, grant unchanged.
  - done and limit reached in the same cycle: done wins, no timeout.
- hold_cnt is 8 bits. It never wraps because it is cleared on every issue.
- enable=0 during HOLD:
  - The owner keeps the grant until done or timeout.
  - Pending requests still accumulate.
  - No new issue happens until enable=1.

## Timing
- Reset values:
  - grant = 0, busy = 0, timeout = 0.
  - pend = 0, ptr = 0, hold_cnt = 0, state = IDLE.
- Reset takes effect immediately (asynchronous) and releases on the clock edge.
- Reset mid-hold drops grant at once and loses all pending requests.
- Grant latency:
  - req sampled at edge t while IDLE and enable=1 gives grant high after edge t.
  - It is visible in the cycle following the request cycle.
- Grant duration:
  - With done never asserted, grant stays high for exactly MAX_HOLD cycles.
  - With done asserted in grant cycle k (k = 1..MAX_HOLD), grant lasts k cycles.
- Release bubble:
  - After release, grant is 0 for exactly one cycle (the IDLE cycle) before the next issue.
  - Back-to-back owners are therefore separated by one idle cycle.
- timeout asserts in the first cycle grant is 0 after a forced release, aligned with the bubble.
- busy always equals |grant, in the same cycle.

## Test plan
- Reset and single request:
  - Hold rstn low, then release; req=4'b0100 pulse for one cycle with enable=1.
  - Required: grant=4'b0100 next cycle.
  - Required: done pulsed on the third grant cycle gives grant=0 after 3 cycles, timeout stays 0, pend=0.
- Round-robin fairness:
  - req=4'b1111 held, enable=1, done pulsed on each owner's first grant cycle.
  - Required grant sequence: 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
- Timeout:
  - MAX_HOLD=8, req=4'b0010, done never asserted.
  - Required: grant=0010 for exactly 8 cycles, then grant=0 with timeout=1 for one cycle.
  - Required: owner re-latched, then re-granted after the bubble.
- Done and timeout collide:
  - done asserted in grant cycle 8 with MAX_HOLD=8.
  - Required: grant drops, timeout=0.
- Enable gating and pending:
  - enable=0; pulse req[3] then req[1] one cycle each; wait 5 cycles; set enable=1 with ptr=0.
  - Required: grant=0010 first, then after release and bubble grant=1000.
  - Required: no grant while enable=0.
- Reset mid-hold:
  - Assert rstn low during grant=0100 with pend=1001.
  - Required: grant=0, busy=0, timeout=0 immediately.
  - Required: after release, no grant until a new req arrives.

Source files
------------

// File: rtl/round_robin_lock_arbiter.sv
// Round-robin lock arbiter: four requesters share one multi-cycle resource.
// The owner keeps its grant until done or until the hold limit forces release.
module round_robin_lock_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] req,
    input  logic       enable,
    input  logic       done,
    output logic [3:0] grant,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    localparam logic [7:0] LIMIT = 8'(MAX_HOLD - 1);

    state_t     state;
    logic [3:0] pend;
    logic [3:0] cand;
    logic [3:0] issue;
    logic [1:0] ptr;
    logic [1:0] win;
    logic [1:0] idx;
    logic       found;
    logic [7:0] hold_cnt;

    // First candidate in rotating order starting at ptr.
    always_comb begin
        cand  = pend | req;
        issue = '0;
        win   = ptr;
        idx   = ptr;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        if (state == IDLE && enable && found) begin
            issue = 4'b0001 << win;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            pend     <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            grant    <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            pend <= (pend | req) & ~issue;
            unique case (state)
                IDLE: begin
                    timeout <= 1'b0;
                    if (|issue) begin
                        grant    <= issue;
                        busy     <= 1'b1;
                        hold_cnt <= '0;
                        ptr      <= win + 2'd1;
                        state    <= HOLD;
                    end else begin
                        grant <= '0;
                        busy  <= 1'b0;
                    end
                end
                HOLD: begin
                    if (done) begin
                        grant   <= '0;
                        busy    <= 1'b0;
                        timeout <= 1'b0;
                        state   <= IDLE;
                    end else if (hold_cnt == LIMIT) begin
                        grant   <= '0;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                        timeout  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
